// File: rtl/floor_req_scheduler.sv
// LOOK-scheduled elevator request collector: latches call buttons into pending lamps and
// hands the motion controller one registered target floor at a time.
module floor_req_scheduler #(
    parameter int unsigned NUM_FLOORS = 8,
    parameter int unsigned FLOOR_W    = 4
) (
    input  logic                  i_clk,
    input  logic                  i_resetN,
    input  logic [NUM_FLOORS-1:0] i_call,
    input  logic [FLOOR_W-1:0]    i_current_floor,
    input  logic                  i_open,
    output logic [FLOOR_W-1:0]    o_target_floor,
    output logic                  o_target_valid,
    output logic                  o_dir_up,
    output logic [NUM_FLOORS-1:0] o_pending
);

    typedef enum logic [1:0] {StIdle, StSweepUp, StSweepDown} state_e;

    state_e                  r_state;
    logic [NUM_FLOORS-1:0]   r_pending;
    logic [FLOOR_W-1:0]      r_target_floor;
    logic                    r_target_valid;
    logic                    r_dir_up;
    logic                    r_open_prev;

    logic [31:0]             w_cur;
    logic                    w_cur_ok;
    logic                    w_arrive;
    logic [NUM_FLOORS-1:0]   w_clr;
    logic [NUM_FLOORS-1:0]   w_eff;
    logic                    w_above;
    logic                    w_below;
    logic                    w_at;
    logic                    w_ge_any;
    logic                    w_le_any;
    logic [FLOOR_W-1:0]      w_lo;
    logic [FLOOR_W-1:0]      w_hi;

    assign w_cur    = 32'(i_current_floor);
    assign w_cur_ok = (w_cur < NUM_FLOORS);
    assign w_arrive = i_open & ~r_open_prev;

    always_comb begin
        w_clr = '0;
        for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
            if (w_arrive && w_cur_ok && (i == w_cur)) w_clr[i] = 1'b1;
        end
    end

    // The floor being arrived at no longer counts as a target, even before pending clears.
    assign w_eff = r_pending & ~w_clr;

    always_comb begin
        w_above  = 1'b0;
        w_below  = 1'b0;
        w_at     = 1'b0;
        w_ge_any = 1'b0;
        w_le_any = 1'b0;
        w_lo     = '0;
        w_hi     = '0;
        for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
            if (w_eff[i]) begin
                if (i > w_cur) w_above = 1'b1;
                if (i < w_cur) w_below = 1'b1;
                if (i == w_cur) w_at = 1'b1;
                if ((i >= w_cur) && !w_ge_any) begin
                    w_ge_any = 1'b1;
                    w_lo     = FLOOR_W'(i);
                end
                if (i <= w_cur) begin
                    w_le_any = 1'b1;
                    w_hi     = FLOOR_W'(i);
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_resetN) begin
        if (!i_resetN) begin
            r_state        <= StIdle;
            r_pending      <= '0;
            r_target_floor <= '0;
            r_target_valid <= 1'b0;
            r_dir_up       <= 1'b1;
            r_open_prev    <= 1'b0;
        end else begin
            r_open_prev <= i_open;
            r_pending   <= (r_pending | i_call) & ~w_clr;
            // An out-of-range floor gives no usable position, so the schedule is frozen.
            if (w_cur_ok) begin
                unique case (r_state)
                    StIdle: begin
                        if (w_above) begin
                            r_state        <= StSweepUp;
                            r_dir_up       <= 1'b1;
                            r_target_floor <= w_lo;
                            r_target_valid <= 1'b1;
                        end else if (w_below) begin
                            r_state        <= StSweepDown;
                            r_dir_up       <= 1'b0;
                            r_target_floor <= w_hi;
                            r_target_valid <= 1'b1;
                        end else if (w_at) begin
                            r_target_floor <= i_current_floor;
                            r_target_valid <= 1'b1;
                        end else begin
                            r_target_valid <= 1'b0;
                        end
                    end
                    StSweepUp: begin
                        if (w_ge_any) begin
                            r_target_floor <= w_lo;
                            r_target_valid <= 1'b1;
                        end else if (w_below) begin
                            r_state        <= StSweepDown;
                            r_dir_up       <= 1'b0;
                            r_target_floor <= w_hi;
                            r_target_valid <= 1'b1;
                        end else begin
                            r_state        <= StIdle;
                            r_target_valid <= 1'b0;
                        end
                    end
                    StSweepDown: begin
                        if (w_le_any) begin
                            r_target_floor <= w_hi;
                            r_target_valid <= 1'b1;
                        end else if (w_above) begin
                            r_state        <= StSweepUp;
                            r_dir_up       <= 1'b1;
                            r_target_floor <= w_lo;
                            r_target_valid <= 1'b1;
                        end else begin
                            r_state        <= StIdle;
                            r_target_valid <= 1'b0;
                        end
                    end
                    default: begin
                        r_state        <= StIdle;
                        r_target_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_target_floor = r_target_floor;
    assign o_target_valid = r_target_valid;
    assign o_dir_up       = r_dir_up;
    assign o_pending      = r_pending;

endmodule

// File: tb/tb_floor_req_scheduler.sv
// Directed bench for floor_req_scheduler: reset sequences plus a table of
// cycle-by-cycle stimulus with hand-computed register values.
module tb_floor_req_scheduler;

    logic       clk;
    logic       resetN;
    logic [7:0] call;
    logic [3:0] cur;
    logic       open;
    logic [3:0] tgt;
    logic       valid;
    logic       dir_up;
    logic [7:0] pend;

    int n_checks = 0;
    int n_errors = 0;

    floor_req_scheduler #(.NUM_FLOORS(8), .FLOOR_W(4)) dut (
        .i_clk          (clk),
        .i_resetN       (resetN),
        .i_call         (call),
        .i_current_floor(cur),
        .i_open         (open),
        .o_target_floor (tgt),
        .o_target_valid (valid),
        .o_dir_up       (dir_up),
        .o_pending      (pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] call;
        logic [3:0] cur;
        logic       open;
        logic [7:0] pend;
        logic [3:0] tgt;
        logic       chk_tgt;
        logic       valid;
        logic       dir;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [7:0] c, input logic [3:0] f, input logic o,
                       input logic [7:0] p, input logic [3:0] t, input logic ct,
                       input logic v, input logic d);
        vec_t x;
        x.call = c; x.cur = f; x.open = o; x.pend = p;
        x.tgt = t; x.chk_tgt = ct; x.valid = v; x.dir = d;
        vecs.push_back(x);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " pend"},  32'(pend),   32'h00);
        check({tag, " valid"}, 32'(valid),  32'h0);
        check({tag, " dir"},   32'(dir_up), 32'h1);
        check({tag, " tgt"},   32'(tgt),    32'h0);
    endtask

    initial begin
        //   call   cur  op  pend   tgt ct v  d
        add(8'h10, 4'd0, 0, 8'h10, 4'd0, 1, 0, 1);  // basic up
        add(8'h00, 4'd0, 0, 8'h10, 4'd4, 1, 1, 1);
        add(8'h00, 4'd2, 0, 8'h10, 4'd4, 1, 1, 1);
        add(8'h00, 4'd4, 1, 8'h00, 4'd0, 0, 0, 1);
        add(8'h00, 4'd4, 0, 8'h00, 4'd0, 0, 0, 1);
        add(8'h40, 4'd1, 0, 8'h40, 4'd0, 0, 0, 1);  // LOOK insertion
        add(8'h00, 4'd1, 0, 8'h40, 4'd6, 1, 1, 1);
        add(8'h08, 4'd2, 0, 8'h48, 4'd6, 1, 1, 1);
        add(8'h00, 4'd2, 0, 8'h48, 4'd3, 1, 1, 1);
        add(8'h00, 4'd3, 1, 8'h40, 4'd6, 1, 1, 1);
        add(8'h00, 4'd3, 0, 8'h40, 4'd6, 1, 1, 1);
        add(8'h00, 4'd6, 1, 8'h00, 4'd0, 0, 0, 1);
        add(8'h00, 4'd6, 0, 8'h00, 4'd0, 0, 0, 1);
        add(8'h82, 4'd5, 0, 8'h82, 4'd0, 0, 0, 1);  // reversal
        add(8'h00, 4'd5, 0, 8'h82, 4'd7, 1, 1, 1);
        add(8'h00, 4'd7, 1, 8'h02, 4'd1, 1, 1, 0);
        add(8'h00, 4'd7, 0, 8'h02, 4'd1, 1, 1, 0);
        add(8'h04, 4'd4, 0, 8'h06, 4'd1, 1, 1, 0);  // downward insertion
        add(8'h00, 4'd3, 0, 8'h06, 4'd2, 1, 1, 0);
        add(8'h04, 4'd2, 1, 8'h02, 4'd1, 1, 1, 0);  // clear wins
        add(8'h04, 4'd2, 1, 8'h06, 4'd1, 1, 1, 0);  // door held open
        add(8'h00, 4'd2, 1, 8'h06, 4'd2, 1, 1, 0);
        add(8'h00, 4'd2, 0, 8'h06, 4'd2, 1, 1, 0);
        add(8'h00, 4'd2, 1, 8'h02, 4'd1, 1, 1, 0);
        add(8'h00, 4'd1, 0, 8'h02, 4'd1, 1, 1, 0);
        add(8'h00, 4'd1, 1, 8'h00, 4'd0, 0, 0, 0);
        add(8'h00, 4'd1, 0, 8'h00, 4'd0, 0, 0, 0);
        add(8'h42, 4'd3, 0, 8'h42, 4'd0, 0, 0, 0);  // tie: up wins
        add(8'h00, 4'd3, 0, 8'h42, 4'd6, 1, 1, 1);
        add(8'h00, 4'd6, 1, 8'h02, 4'd1, 1, 1, 0);
        add(8'h00, 4'd6, 0, 8'h02, 4'd1, 1, 1, 0);
        add(8'h00, 4'd1, 1, 8'h00, 4'd0, 0, 0, 0);
        add(8'h00, 4'd1, 0, 8'h00, 4'd0, 0, 0, 0);
        add(8'h08, 4'd3, 0, 8'h08, 4'd0, 0, 0, 0);  // in place
        add(8'h00, 4'd3, 0, 8'h08, 4'd3, 1, 1, 0);
        add(8'h00, 4'd3, 1, 8'h00, 4'd0, 0, 0, 0);
        add(8'h00, 4'd3, 0, 8'h00, 4'd0, 0, 0, 0);
        add(8'h20, 4'd9, 0, 8'h20, 4'd0, 0, 0, 0);  // out-of-range floor
        add(8'h00, 4'd9, 0, 8'h20, 4'd0, 0, 0, 0);
        add(8'h00, 4'd9, 1, 8'h20, 4'd0, 0, 0, 0);
        add(8'h00, 4'd9, 0, 8'h20, 4'd0, 0, 0, 0);
        add(8'h00, 4'd2, 0, 8'h20, 4'd5, 1, 1, 1);
        add(8'h20, 4'd2, 0, 8'h20, 4'd5, 1, 1, 1);  // saturation
        add(8'h20, 4'd2, 0, 8'h20, 4'd5, 1, 1, 1);

        // Reset held with all buttons pressed.
        resetN = 1'b0; call = 8'hFF; cur = 4'd0; open = 1'b0;
        repeat (4) @(posedge clk);
        #1 check_reset_vals("reset");
        @(negedge clk) resetN = 1'b1;
        @(posedge clk);
        #1 check("reset release pend", 32'(pend), 32'hFF);
        @(negedge clk) begin resetN = 1'b0; call = 8'h00; end
        #1 check("reset async pend", 32'(pend), 32'h00);
        @(negedge clk) resetN = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            call = vecs[i].call; cur = vecs[i].cur; open = vecs[i].open;
            @(posedge clk);
            #1;
            check($sformatf("v%0d pend", i),  32'(pend),   32'(vecs[i].pend));
            check($sformatf("v%0d valid", i), 32'(valid),  32'(vecs[i].valid));
            check($sformatf("v%0d dir", i),   32'(dir_up), 32'(vecs[i].dir));
            if (vecs[i].chk_tgt)
                check($sformatf("v%0d tgt", i), 32'(tgt), 32'(vecs[i].tgt));
        end

        // Mid-run reset: outputs must drop between clock edges.
        @(negedge clk) call = 8'h00;
        check("midrun precondition valid", 32'(valid), 32'h1);
        #2 resetN = 1'b0;
        #1 check_reset_vals("midrun");
        @(negedge clk) resetN = 1'b1;
        @(posedge clk);
        #1 check("after midrun pend", 32'(pend), 32'h00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/floor_req_scheduler.md
Name: floor_req_scheduler

Overview:
- Collects floor call buttons from all floors and the cab into a pending-request register.
- Schedules them with LOOK: keep direction while requests remain ahead, then reverse.
- Feeds one target floor at a time to the elevator motion controller.
- Sits between the call-button inputs and the motion controller. It consumes the controller's current floor and door-open indication. It drives the target the controller moves toward.

Parameters:
- NUM_FLOORS, 8, number of served floors (2..16).
- FLOOR_W, 4, width of floor-number buses; must satisfy 2^FLOOR_W >= NUM_FLOORS.

Ports:
- clk  in  1  system clock.
- resetN  in  1  asynchronous active-low reset.
- call  in  NUM_FLOORS  call buttons, one bit per floor, level or pulse; OR-ed into pending.
- current_floor  in  FLOOR_W  floor the car is at or passing, from the motion controller.
- open  in  1  door-open from the motion controller; its rising edge is the arrival event.
- target_floor  out  FLOOR_W  floor the car shall move to.
- target_valid  out  1  target_floor holds a pending request.
- dir_up  out  1  current sweep direction; 1 = up.
- pending  out  NUM_FLOORS  outstanding requests (drives button lamps).

Behaviour:
- Reset (async, resetN=0):
  - pending=0, target_floor=0, target_valid=0, dir_up=1, state=IDLE, open edge detector cleared.
  - Reset mid-operation drops all requests immediately.
- All outputs are registered.
- Set latency: call bit at edge n -> pending bit set at n+1 -> target_floor/target_valid updated at n+2.
- Arrival event: open=1 at this edge and open=0 at the previous edge (registered detector).
  - On arrival, pending[current_floor] clears at the next edge.
  - If call[current_floor]=1 in the same cycle as the arrival, clear wins (door is already open).
  - call[current_floor] while open stays 1 and no arrival event occurs: bit is set, served at the next arrival.
- current_floor >= NUM_FLOORS: no clear, no target computed from it; treated as no requests ahead/behind, so state is held.
- States and transitions: IDLE, SWEEP_UP, SWEEP_DOWN.
  - IDLE: target_valid=0.
    - pending bit above current_floor -> SWEEP_UP, dir_up=1.
    - Else pending bit below -> SWEEP_DOWN, dir_up=0.
    - Else only pending[current_floor] set -> stay IDLE, target_valid=1, target_floor=current_floor (controller opens in place).
    - When both above and below are pending, up wins.
  - SWEEP_UP: target_floor = lowest pending floor >= current_floor.
    - Floor equal to current counts only when not yet arrived; a target appearing between the car and the old target replaces it (LOOK).
    - No pending above or at current: if any below -> SWEEP_DOWN, else -> IDLE.
  - SWEEP_DOWN: mirror of SWEEP_UP, using the highest pending floor <= current_floor.
    - None: if any above -> SWEEP_UP, else -> IDLE.
- target_valid=1 in both sweep states while the chosen target bit is pending.
- target_floor changes only on a clock edge; it never glitches within a cycle.
- Simultaneous events:
  - Multiple call bits in one cycle: all latch.
  - A new call and an arrival in the same cycle: both applied in that cycle.
  - A direction change and a new call in the same cycle: the new call is included in the next-cycle target evaluation.
- pending saturates: repeated presses of an already-set bit have no effect.
- No wrap-around: floor 0 and floor NUM_FLOORS-1 are hard ends.

Test Plan:
- Reset: resetN=0 for 4 cycles with call=8'hFF -> pending=0, target_valid=0, dir_up=1, target_floor=0; after release, pending=8'hFF 1 cycle after the first edge.
- Basic up: current_floor=0, call pulse bit 4 -> 2 cycles later target_floor=4, target_valid=1, dir_up=1; open rising at current_floor=4 -> pending[4]=0, then target_valid=0, IDLE.
- LOOK insertion: car moving up toward 6 at current_floor=2, call bit 3 -> target_floor becomes 3; after arrival at 3 -> target_floor=6.
- Reversal: at floor 5 with pending={1,7}, dir_up=1 -> serves 7 first; after arrival at 7 -> dir_up=0, target_floor=1.
- Tie and in-place: IDLE at floor 3 with call bits 1 and 6 in the same cycle -> SWEEP_UP, target 6. Separately, call bit 3 at floor 3 while idle -> target_valid=1, target_floor=3; open edge clears it.
- Clear-wins and reset mid-run: call[2] in the same cycle as the arrival at floor 2 -> pending[2]=0. Separately, resetN low while target_valid=1 -> all outputs return to reset values asynchronously.
